// File: rtl/audio_pkg.sv
// Shared audio capture definitions: FSM state encodings, default I2S slot
// width and frame sizing helper.
package audio_pkg;

  localparam int unsigned I2S_SLOT_BITS = 32'd32;

  typedef enum logic [1:0] {
    CAP_SYNC  = 2'd0,
    CAP_LEFT  = 2'd1,
    CAP_RIGHT = 2'd2
  } cap_state_e;

  typedef enum logic {
    EMIT_IDLE = 1'b0,
    EMIT_BUSY = 1'b1
  } emit_state_e;

  function automatic int unsigned BYTES_PER_FRAME(input int unsigned sample_bits);
    return (32'd2 * sample_bits) / 32'd8;
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings bclk/lrck/sdata into the clk_i domain and produces registered bclk
// edge pulses; lrck/sdata outputs are aligned with the pulses.
module i2s_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic bclk_i,
  input  logic lrck_i,
  input  logic sdata_i,
  output logic bclk_rise_o,
  output logic bclk_fall_o,
  output logic lrck_o,
  output logic sdata_o
);

  logic [1:0] bclk_sync_q;
  logic [1:0] lrck_sync_q;
  logic [1:0] sdata_sync_q;
  logic       bclk_prev_q;
  logic       rise_q;
  logic       fall_q;
  logic       lrck_q;
  logic       sdata_q;

  // Synchronizer chains, bclk history stage and edge pulse registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bclk_sync_q  <= 2'b00;
      lrck_sync_q  <= 2'b00;
      sdata_sync_q <= 2'b00;
      bclk_prev_q  <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[0], bclk_i};
      lrck_sync_q  <= {lrck_sync_q[0], lrck_i};
      sdata_sync_q <= {sdata_sync_q[0], sdata_i};
      bclk_prev_q  <= bclk_sync_q[1];
      rise_q       <= bclk_sync_q[1] & ~bclk_prev_q;
      fall_q       <= ~bclk_sync_q[1] & bclk_prev_q;
      lrck_q       <= lrck_sync_q[1];
      sdata_q      <= sdata_sync_q[1];
    end
  end

  assign bclk_rise_o = rise_q;
  assign bclk_fall_o = fall_q;
  assign lrck_o      = lrck_q;
  assign sdata_o     = sdata_q;

endmodule

// File: rtl/i2s_capture.sv
// Slave-mode I2S receiver: oversamples the serial stream, deserializes L/R
// words and writes each stereo frame as bytes into the output FIFO.
module i2s_capture
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = 32'd24,
  parameter int unsigned SLOT_BITS   = I2S_SLOT_BITS,
  parameter int unsigned DROP_CNT_W  = 32'd16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  i2s_bclk_i,
  input  logic                  i2s_lrck_i,
  input  logic                  i2s_sdata_i,
  output logic                  wr_out_fifo_clk_o,
  output logic                  wr_out_fifo_en_o,
  output logic [7:0]            wr_out_fifo_data_o,
  input  logic                  wr_out_fifo_full_i,
  input  logic                  wr_out_fifo_afull_i,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] dropped_frames_o,
  output logic                  locked_o
);

  localparam int unsigned NBYTES   = BYTES_PER_FRAME(SAMPLE_BITS);
  localparam int unsigned BUF_W    = 32'd2 * SAMPLE_BITS;
  localparam int unsigned CNT_W    = $clog2(SLOT_BITS + 32'd1);
  localparam int unsigned IDX_W    = $clog2(NBYTES);
  localparam int unsigned SH_IDX_W = $clog2(SAMPLE_BITS);

  logic rise_s;
  logic lrck_s;
  logic sdata_s;
  logic bclk_fall_unused_s;

  cap_state_e               cap_state_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic [SAMPLE_BITS-1:0]   shift_q;
  logic [SAMPLE_BITS-1:0]   shift_d;
  logic [SH_IDX_W-1:0]      sh_idx_s;
  logic                     lrck_prev_q;
  logic [SAMPLE_BITS-1:0]   left_q;
  logic [SAMPLE_BITS-1:0]   right_q;
  logic                     frame_done_q;
  logic                     locked_q;

  emit_state_e              emit_state_q;
  logic [BUF_W-1:0]         emit_buf_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     wr_en_q;
  logic [7:0]               wr_data_q;
  logic                     overflow_q;
  logic [DROP_CNT_W-1:0]    drop_cnt_q;

  i2s_sync_edge u_sync (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .bclk_i      (i2s_bclk_i),
    .lrck_i      (i2s_lrck_i),
    .sdata_i     (i2s_sdata_i),
    .bclk_rise_o (rise_s),
    .bclk_fall_o (bclk_fall_unused_s),
    .lrck_o      (lrck_s),
    .sdata_o     (sdata_s)
  );

  // Places the current serial bit MSB-first; bits past the sample width are ignored.
  always_comb begin
    shift_d  = shift_q;
    sh_idx_s = SH_IDX_W'(SAMPLE_BITS - 32'd1 - 32'(bit_cnt_q));
    if (bit_cnt_q < CNT_W'(SAMPLE_BITS)) begin
      shift_d[sh_idx_s] = sdata_s;
    end else begin
      shift_d = shift_q;
    end
  end

  // Capture FSM: frame alignment, slot bit counting and word latching.
  // The rise carrying an lrck change still holds the closing slot's last bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cap_state_q  <= CAP_SYNC;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      lrck_prev_q  <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (rise_s) begin
        lrck_prev_q <= lrck_s;
      end
      if (!enable_i) begin
        cap_state_q <= CAP_SYNC;
        locked_q    <= 1'b0;
      end else if (rise_s) begin
        case (cap_state_q)
          CAP_SYNC: begin
            if (lrck_prev_q && !lrck_s) begin
              cap_state_q <= CAP_LEFT;
              bit_cnt_q   <= '0;
              shift_q     <= '0;
              locked_q    <= 1'b1;
            end
          end
          CAP_LEFT, CAP_RIGHT: begin
            if (lrck_s != lrck_prev_q) begin
              bit_cnt_q <= '0;
              shift_q   <= '0;
              if (cap_state_q == CAP_LEFT) begin
                left_q      <= shift_d;
                cap_state_q <= CAP_RIGHT;
              end else begin
                right_q      <= shift_d;
                frame_done_q <= 1'b1;
                cap_state_q  <= CAP_LEFT;
              end
            end else if (bit_cnt_q == CNT_W'(SLOT_BITS)) begin
              cap_state_q <= CAP_SYNC;
              locked_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              shift_q   <= shift_d;
            end
          end
          default: begin
            cap_state_q <= CAP_SYNC;
            locked_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Emit FSM: accepts or drops whole frames and streams accepted bytes to the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      emit_state_q <= EMIT_IDLE;
      emit_buf_q   <= '0;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 8'h00;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (emit_state_q)
        EMIT_IDLE: begin
          if (frame_done_q && !wr_out_fifo_afull_i) begin
            emit_buf_q   <= {left_q, right_q};
            idx_q        <= '0;
            emit_state_q <= EMIT_BUSY;
          end
        end
        EMIT_BUSY: begin
          if (!wr_out_fifo_full_i) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= emit_buf_q[BUF_W-1 -: 8];
            emit_buf_q <= {emit_buf_q[BUF_W-9:0], 8'h00};
            idx_q      <= idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NBYTES - 32'd1)) begin
              emit_state_q <= EMIT_IDLE;
            end
          end
        end
        default: emit_state_q <= EMIT_IDLE;
      endcase
      // A frame finishing while busy (including on the last byte) or while afull is lost whole.
      if (frame_done_q && ((emit_state_q != EMIT_IDLE) || wr_out_fifo_afull_i)) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
          drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
      end
    end
  end

  assign wr_out_fifo_clk_o  = clk_i;
  assign wr_out_fifo_en_o   = wr_en_q;
  assign wr_out_fifo_data_o = wr_data_q;
  assign overflow_o         = overflow_q;
  assign dropped_frames_o   = drop_cnt_q;
  assign locked_o           = locked_q;

endmodule

// File: tb/tb_i2s_capture.sv
// Bench for i2s_capture: drives an I2S stream at clk/8 and scores FIFO writes
// against bytes queued from the stimulus.
module tb_i2s_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        full;
  logic        afull;
  logic        wr_clk;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        overflow;
  logic [15:0] dropped;
  logic        locked;

  always #20 clk = ~clk;

  i2s_capture #(
    .SAMPLE_BITS (24),
    .SLOT_BITS   (32),
    .DROP_CNT_W  (16)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .enable_i            (enable),
    .i2s_bclk_i          (bclk),
    .i2s_lrck_i          (lrck),
    .i2s_sdata_i         (sdata),
    .wr_out_fifo_clk_o   (wr_clk),
    .wr_out_fifo_en_o    (wr_en),
    .wr_out_fifo_data_o  (wr_data),
    .wr_out_fifo_full_i  (full),
    .wr_out_fifo_afull_i (afull),
    .overflow_o          (overflow),
    .dropped_frames_o    (dropped),
    .locked_o            (locked)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        af;
  } frame_t;

  frame_t     vec[7];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_strobe = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  int         pos = 0;
  int         base = 0;
  int         s0 = 0;
  bit         gap_chk = 1'b1;
  logic       carry = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe pops one expected byte; in-frame strobes must be back to back.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got byte %02h, expected no write", wr_data);
      end else begin
        check("byte", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
      end
      if (pos != 0 && gap_chk) check("strobe_gap", 32'(cyc - last_cyc), 32'd1);
      last_cyc = cyc;
      pos = (pos + 1) % 6;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic lr, input logic sd);
    bclk = 1'b0;
    lrck = lr;
    sdata = sd;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One lrck slot of len bclk periods; the first period carries the previous slot's last bit.
  task automatic send_slot(input logic lr, input logic [31:0] w, input int len, input logic af);
    logic [31:0] sh;
    sh = w;
    send_bit(lr, carry);
    for (int i = 1; i < len; i++) begin
      if (i == 8) afull = af;
      send_bit(lr, sh[31]);
      sh = sh << 1;
    end
    carry = sh[31];
  endtask

  task automatic run_frame(input logic [23:0] l, input logic [23:0] r, input int len,
                           input logic af, input logic expect_wr);
    logic [23:0] m;
    logic [23:0] el;
    logic [23:0] er;
    int          n;
    send_slot(1'b0, {l, 8'h00}, len, af);
    send_slot(1'b1, {r, 8'h00}, len, af);
    n = (len < 24) ? len : 24;
    m = 24'hFFFFFF;
    m = m << (24 - n);
    el = l & m;
    er = r & m;
    if (expect_wr) begin
      exp_q.push_back(el[23:16]);
      exp_q.push_back(el[15:8]);
      exp_q.push_back(el[7:0]);
      exp_q.push_back(er[23:16]);
      exp_q.push_back(er[15:8]);
      exp_q.push_back(er[7:0]);
    end
  endtask

  task automatic resync();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("locked_when_disabled", 32'(locked), 32'd0);
    enable = 1'b1;
    carry = 1'b0;
  endtask

  task automatic wait_strobes(input int target);
    for (int c = 0; c < 3000; c++) begin
      if (n_strobe >= target) break;
      @(negedge clk);
    end
    if (n_strobe < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL strobe_wait: got %0d strobes, expected %0d", n_strobe, target);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    bclk = 1'b0;
    lrck = 1'b0;
    sdata = 1'b0;
    full = 1'b0;
    afull = 1'b0;
    vec[0] = '{l: 24'h123456, r: 24'hABCDEF, af: 1'b0};
    vec[1] = '{l: 24'h000000, r: 24'hFFFFFF, af: 1'b0};
    vec[2] = '{l: 24'h800001, r: 24'h7FFFFE, af: 1'b0};
    vec[3] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, af: 1'b1};
    vec[4] = '{l: 24'h111111, r: 24'h222222, af: 1'b1};
    vec[5] = '{l: 24'h333333, r: 24'h444444, af: 1'b1};
    vec[6] = '{l: 24'hC0FFEE, r: 24'h0BADF0, af: 1'b0};
    repeat (4) @(negedge clk);
    check("rst_en", 32'(wr_en), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("fifo_clk", 32'(wr_clk), 32'(clk));
    reset = 1'b0;
    enable = 1'b1;

    // Table-driven frames: three with afull at frame_done must be dropped and counted.
    send_slot(1'b1, 32'd0, 32, 1'b0);
    for (int k = 0; k < 7; k++) begin
      run_frame(vec[k].l, vec[k].r, 32, vec[k].af, !vec[k].af);
      check("locked_stream", 32'(locked), 32'd1);
    end
    send_slot(1'b0, 32'd0, 32, 1'b0);
    repeat (20) @(negedge clk);
    check("table_drained", 32'(exp_q.size()), 32'd0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("dropped_3", 32'(dropped), 32'd3);

    // FIFO full for 10 clk after the second byte.
    resync();
    send_slot(1'b1, 32'd0, 32, 1'b0);
    base = n_strobe;
    gap_chk = 1'b0;
    fork
      begin
        run_frame(24'h5A0F3C, 24'h96E1D2, 32, 1'b0, 1'b1);
        send_slot(1'b0, 32'd0, 32, 1'b0);
      end
      begin
        wait_strobes(base + 2);
        full = 1'b1;
        s0 = n_strobe;
        repeat (10) @(negedge clk);
        check("no_strobe_while_full", 32'(n_strobe - s0), 32'd0);
        full = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    gap_chk = 1'b1;
    check("full_drained", 32'(exp_q.size()), 32'd0);
    check("full_strobes", 32'(n_strobe - base), 32'd6);

    // Static lrck for 40 bclk periods loses lock; the next falling lrck relocks.
    resync();
    send_slot(1'b1, 32'd0, 32, 1'b0);
    run_frame(24'h0F1E2D, 24'h3C4B5A, 32, 1'b0, 1'b1);
    send_slot(1'b0, 32'd0, 40, 1'b0);
    check("unlocked_static_lrck", 32'(locked), 32'd0);
    send_slot(1'b1, 32'd0, 32, 1'b0);
    check("still_unlocked", 32'(locked), 32'd0);
    run_frame(24'h654321, 24'hFEDCBA, 32, 1'b0, 1'b1);
    check("relocked", 32'(locked), 32'd1);
    send_slot(1'b0, 32'd0, 32, 1'b0);
    repeat (20) @(negedge clk);
    check("relock_drained", 32'(exp_q.size()), 32'd0);
    check("dropped_unchanged", 32'(dropped), 32'd3);

    // 16-bit slots: missing LSBs of the 24-bit word read as zero.
    resync();
    send_slot(1'b1, 32'd0, 16, 1'b0);
    run_frame(24'hBEEF00, 24'h123400, 16, 1'b0, 1'b1);
    send_slot(1'b0, 32'd0, 16, 1'b0);
    repeat (20) @(negedge clk);
    check("short_slot_drained", 32'(exp_q.size()), 32'd0);

    // Reset after the third byte abandons the rest of the frame.
    resync();
    send_slot(1'b1, 32'd0, 32, 1'b0);
    base = n_strobe;
    fork
      begin
        run_frame(24'hA1B2C3, 24'hD4E5F6, 32, 1'b0, 1'b1);
        send_slot(1'b0, 32'd0, 32, 1'b0);
      end
      begin
        wait_strobes(base + 3);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_en", 32'(wr_en), 32'd0);
        check("mid_rst_data", 32'(wr_data), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_dropped", 32'(dropped), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        pos = 0;
      end
    join
    repeat (20) @(negedge clk);
    check("no_write_after_reset", 32'(n_strobe - base), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
